multi_cycle_control: RTL and testbench

Control FSM that sequences a shared-memory, multi-cycle RV32I datapath (single ALU, single memory port, instruction register) through fetch/decode/execute/memory/writeback. It is the multi-cycle successor to the single-cycle core's combinational control unit. It produces every datapath mux select and write enable, handles a memory-ready handshake, and flags illegal opcodes.

---
 rtl/multi_cycle_pkg.sv | 60 ++++++
 rtl/multi_cycle_control_alu_decoder.sv | 37 +++
 rtl/multi_cycle_control.sv | 188 ++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_pkg.sv
// Shared encodings for the multi-cycle RV32I core: FSM states, opcodes,
// ALUOp codes and every datapath mux-select / ALU-control value. The
// datapath imports the same package so both sides agree on the encodings.
package multi_cycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_RESULT = 1'b1;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/multi_cycle_control_alu_decoder.sv
// Combinational ALU decoder.
// Ports:
//   alu_op      in  ALUOp from the control FSM (add / sub / by funct3)
//   funct3      in  instr[14:12]
//   op_b5       in  instr[5]; distinguishes R-type (1) from I-type (0)
//   funct7b5    in  instr[30]
//   alu_control out ALU operation select
module alu_decoder
  import multi_cycle_pkg::*;
(
  input  aluop_e     alu_op,
  input  logic [2:0] funct3,
  input  logic       op_b5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only register-register with funct7b5 set is sub; addi has no sub form.
          3'b000:  alu_control = (op_b5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Control FSM for a shared-memory multi-cycle RV32I datapath.
// Sequences fetch/decode/execute/memory/writeback, drives every mux select
// and write enable, waits on the memory-ready handshake, flags illegal
// opcodes and counts retired instructions.
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   op, funct3, funct7b5  instruction fields from the IR
//   zero                  ALU zero flag (branch resolution)
//   mem_ready             memory completes its access this cycle
//   pc_write .. reg_write datapath enables and mux selects
//   illegal_instr         sticky unsupported-opcode flag
//   instr_retired         completed-instruction counter (wraps)
//   state_o               current FSM state for debug
module multi_cycle_control
  import multi_cycle_pkg::*;
#(
  parameter int CNT_WIDTH       = 32,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic [2:0]           alu_control,
  output logic                 reg_write,
  output logic                 illegal_instr,
  output logic [CNT_WIDTH-1:0] instr_retired,
  output logic [3:0]           state_o
);

  state_e               state_q, state_d;
  logic                 illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 retire;
  logic                 pc_update;
  logic                 branch;
  aluop_e               alu_op;

  // Next state, sticky illegal flag and retire counter.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              state_d   = S_TRAP;
              illegal_d = 1'b1;
            end else begin
              // Treated as a NOP: back to fetch without counting a retire.
              state_d = S_FETCH;
            end
          end
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    begin state_d = S_FETCH; retire = 1'b1; end
      S_MEMWRITE: if (mem_ready) begin state_d = S_FETCH; retire = 1'b1; end
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    begin state_d = S_FETCH; retire = 1'b1; end
      S_BEQ:      begin state_d = S_FETCH; retire = 1'b1; end
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
    retired_d = retire ? retired_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1} : retired_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // State-decoded outputs; the only input-dependent terms are the
  // mem_ready gating in FETCH and the branch-taken term of pc_write.
  always_comb begin
    adr_src    = ADR_PC;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    reg_write  = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    alu_op     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: adr_src = ADR_RESULT;
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = ADR_RESULT;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // Immediate format follows the opcode alone.
  always_comb begin
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op_b5       (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

  assign pc_write      = pc_update | (branch & zero);
  assign illegal_instr = illegal_q;
  assign instr_retired = retired_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control. A per-instruction reference
// model builds the expected cycle-by-cycle state walk (including memory
// wait cycles) and the control word each step must present.
module tb_multi_cycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  op = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7b5 = 1'b0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_control;
  logic [31:0] instr_retired;
  logic [3:0]  state_o;

  int          checks = 0;
  int          errors = 0;
  int unsigned retired_model = 0;
  logic        illegal_model = 1'b0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1110011;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] alu;
    logic       reg_write;
  } ctl_t;

  multi_cycle_control #(.CNT_WIDTH(32), .TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .reg_write(reg_write),
    .illegal_instr(illegal_instr), .instr_retired(instr_retired), .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  // ALU operation an R/I arithmetic instruction asks for.
  function automatic logic [2:0] arith_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o == RT && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] imm_for(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  // Control word each step of an instruction must present.
  function automatic ctl_t exp_ctl(input int st, input logic mr, input logic z,
                                   input logic [6:0] o, input logic [2:0] f3, input logic f7);
    ctl_t c;
    c = '0;
    case (st)
      0:  begin c.b = 2'b10; c.result_src = 2'b10; c.ir_write = mr; c.pc_write = mr; end
      1:  begin c.a = 2'b01; c.b = 2'b01; end
      2:  begin c.a = 2'b10; c.b = 2'b01; end
      3:  c.adr_src = 1'b1;
      4:  begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      5:  begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      6:  begin c.a = 2'b10; c.alu = arith_alu(o, f3, f7); end
      7:  c.reg_write = 1'b1;
      8:  begin c.a = 2'b10; c.b = 2'b01; c.alu = arith_alu(o, f3, f7); end
      9:  begin c.a = 2'b01; c.b = 2'b10; c.pc_write = 1'b1; end
      10: begin c.a = 2'b10; c.alu = 3'b001; c.pc_write = z; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctl_t observed();
    ctl_t c;
    c.pc_write = pc_write;  c.adr_src = adr_src;  c.mem_write = mem_write;
    c.ir_write = ir_write;  c.result_src = result_src;
    c.a = alu_src_a;        c.b = alu_src_b;      c.alu = alu_control;
    c.reg_write = reg_write;
    return c;
  endfunction

  // Executes one instruction from FETCH. wf = mem_ready-low cycles in FETCH,
  // wm = mem_ready-low cycles in MEMREAD/MEMWRITE (extra TRAP cycles for illegal).
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z, input int wf, input int wm);
    int   st_q[$];
    logic mr_q[$];
    bit   retires;
    ctl_t e, g;
    retires = 1'b1;
    for (int i = 0; i < wf; i++) begin st_q.push_back(0); mr_q.push_back(1'b0); end
    st_q.push_back(0); mr_q.push_back(1'b1);
    st_q.push_back(1); mr_q.push_back(1'($urandom_range(0, 1)));
    case (o)
      RT: begin st_q.push_back(6); st_q.push_back(7); end
      IT: begin st_q.push_back(8); st_q.push_back(7); end
      JL: begin st_q.push_back(9); st_q.push_back(7); end
      BQ: st_q.push_back(10);
      LW: begin
        st_q.push_back(2); mr_q.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < wm; i++) begin st_q.push_back(3); mr_q.push_back(1'b0); end
        st_q.push_back(3); mr_q.push_back(1'b1);
        st_q.push_back(4);
      end
      SW: begin
        st_q.push_back(2); mr_q.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < wm; i++) begin st_q.push_back(5); mr_q.push_back(1'b0); end
        st_q.push_back(5); mr_q.push_back(1'b1);
      end
      default: begin
        retires = 1'b0;
        for (int i = 0; i < wm + 2; i++) st_q.push_back(11);
      end
    endcase
    while (mr_q.size() < st_q.size()) mr_q.push_back(1'($urandom_range(0, 1)));

    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    for (int k = 0; k < st_q.size(); k++) begin
      mem_ready = mr_q[k];
      if (st_q[k] == 11) illegal_model = 1'b1;
      @(negedge clk);
      checks++;
      if (state_o !== 4'(st_q[k])) begin
        errors++;
        $display("FAIL %s state step %0d: got %0d required %0d", name, k, state_o, st_q[k]);
      end
      e = exp_ctl(st_q[k], mr_q[k], z, o, f3, f7);
      g = observed();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s controls step %0d: got %b required %b", name, k, g, e);
      end
      checks++;
      if (illegal_instr !== illegal_model || instr_retired !== retired_model) begin
        errors++;
        $display("FAIL %s flags step %0d: got illegal=%b retired=%0d required illegal=%b retired=%0d",
                 name, k, illegal_instr, instr_retired, illegal_model, retired_model);
      end
      if (st_q[k] == 1) begin
        checks++;
        if (imm_src !== imm_for(o)) begin
          errors++;
          $display("FAIL %s imm_src: got %b required %b", name, imm_src, imm_for(o));
        end
      end
      @(posedge clk); #1;
    end
    if (retires) retired_model++;
    checks++;
    if (state_o !== (retires ? 4'd0 : 4'd11) || instr_retired !== retired_model) begin
      errors++;
      $display("FAIL %s end: got state=%0d retired=%0d required state=%0d retired=%0d",
               name, state_o, instr_retired, retires ? 0 : 11, retired_model);
    end
    $display("instr %-8s op=%b f3=%b f7=%b zero=%b waits=%0d/%0d cycles=%0d retired=%0d",
             name, o, f3, f7, z, wf, wm, st_q.size(), instr_retired);
  endtask

  task automatic apply_reset();
    rst = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (state_o !== 4'd0 || instr_retired !== 32'd0 || illegal_instr !== 1'b0 ||
        mem_write !== 1'b0 || reg_write !== 1'b0) begin
      errors++;
      $display("FAIL reset: got state=%0d retired=%0d illegal=%b mw=%b rw=%b required 0/0/0/0/0",
               state_o, instr_retired, illegal_instr, mem_write, reg_write);
    end
    rst = 1'b0;
    retired_model = 0;
    illegal_model = 1'b0;
    $display("reset applied");
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (observed() !== exp_ctl(0, 1'b0, 1'b0, 7'd0, 3'd0, 1'b0)) begin
      errors++;
      $display("FAIL reset_fetch_idle: got %b required %b", observed(),
               exp_ctl(0, 1'b0, 1'b0, 7'd0, 3'd0, 1'b0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    run_instr("sub", RT, 3'b000, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait", LW, 3'b010, 1'b0, 1'b0, 0, 2);
  endtask

  task automatic test_beq();
    run_instr("beq_tk", BQ, 3'b000, 1'b0, 1'b1, 0, 0);
    run_instr("beq_nt", BQ, 3'b000, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_sw_wait();
    run_instr("sw_wait", SW, 3'b010, 1'b0, 1'b0, 1, 1);
  endtask

  task automatic test_random();
    logic [6:0] ops [6];
    ops = '{RT, IT, JL, LW, SW, BQ};
    for (int n = 0; n < 40; n++) begin
      run_instr("rand", ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_trap();
    run_instr("illegal", BAD, 3'b000, 1'b0, 1'b0, 0, 4);
    apply_reset();
  endtask

  task automatic test_reset_mid();
    run_instr("add", RT, 3'b000, 1'b0, 1'b0, 0, 0);
    op = LW; funct3 = 3'b010;
    mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state_o !== 4'd3 || adr_src !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_setup: got state=%0d adr_src=%b required 3/1", state_o, adr_src);
    end
    @(posedge clk); #1;
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_sw_wait();
    test_random();
    test_trap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
